// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I subset core (lw, sw, add, sub, and, or, slt, addi, andi,
// ori, slti, beq, jal) that uses one shared memory port for fetch and data.
// Each instruction takes several states. Memory request signals are registered
// so they stay stable until the acknowledge cycle. Illegal or misaligned
// operations halt the core in TRAP, and only reset leaves that state.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [31:0]       o_memWdata,
  input  logic [31:0]       i_memRdata,
  input  logic              i_memAck,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retire,
  output logic              o_trap
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   oldPc_q, oldPc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         imm_q, imm_d;
  logic [31:0]         aluOut_q, aluOut_d;
  logic [31:0]         mdr_q, mdr_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [31:0]         memWdata_q, memWdata_d;
  logic                trap_q, trap_d;

  logic                rfWe;
  logic [31:0]         rfWdata;
  logic                retire;

  logic [31:0]         regs [32];

  logic [6:0]          opcode;
  logic [4:0]          rd, rs1, rs2;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [31:0]         immI, immS, immB, immJ;
  logic [31:0]         rs1Val, rs2Val;
  logic                aluFnLegal, rLegal;
  logic [31:0]         addrSum;
  logic [ADDR_W-1:0]   branchTarget;
  logic [31:0]         oldPc32, linkAddr;
  logic                isSub;
  logic [31:0]         aluB, aluResult;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign immI = {{20{ir_q[31]}}, ir_q[31:20]};
  assign immS = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign immB = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign immJ = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign aluFnLegal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);
  assign rLegal     = (aluFnLegal && (funct7 == 7'b0000000)) ||
                      ((funct3 == 3'b000) && (funct7 == 7'b0100000));

  assign addrSum      = a_q + imm_q;
  assign branchTarget = oldPc_q + imm_q[ADDR_W-1:0];

  assign isSub = (state_q == EXECR) && funct7[5];
  assign aluB  = (state_q == EXECR) ? b_q : imm_q;

  function automatic logic [31:0] aluCalc(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000:  return sub ? (x - y) : (x + y);
      3'b010:  return {31'd0, ($signed(x) < $signed(y))};
      3'b110:  return x | y;
      3'b111:  return x & y;
      default: return 32'd0;
    endcase
  endfunction

  assign aluResult = aluCalc(funct3, isSub, a_q, aluB);

  // Widen the old PC to 32 bits so the jal link value can be formed for any ADDR_W
  always_comb begin
    oldPc32 = '0;
    oldPc32[ADDR_W-1:0] = oldPc_q;
    linkAddr = oldPc32 + 32'd4;
  end

  // Next-state and datapath update for every FSM state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    oldPc_d    = oldPc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    aluOut_d   = aluOut_q;
    mdr_d      = mdr_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    trap_d     = trap_q;
    rfWe       = 1'b0;
    rfWdata    = aluOut_q;
    retire     = 1'b0;

    case (state_q)
      FETCH: begin
        if (!memReq_q) begin
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = pc_q;
        end else if (i_memAck) begin
          ir_d     = i_memRdata;
          oldPc_d  = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
          memReq_d = 1'b0;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        a_d = rs1Val;
        b_d = rs2Val;
        case (opcode)
          OP_LOAD: begin
            imm_d   = immI;
            state_d = (funct3 == 3'b010) ? MEMADR : TRAP;
          end
          OP_STORE: begin
            imm_d   = immS;
            state_d = (funct3 == 3'b010) ? MEMADR : TRAP;
          end
          OP_REG:    state_d = rLegal ? EXECR : TRAP;
          OP_IMM: begin
            imm_d   = immI;
            state_d = aluFnLegal ? EXECI : TRAP;
          end
          OP_BRANCH: begin
            imm_d   = immB;
            state_d = (funct3 == 3'b000) ? BEQ : TRAP;
          end
          OP_JAL: begin
            imm_d   = immJ;
            state_d = JAL;
          end
          default:   state_d = TRAP;
        endcase
        if (state_d == TRAP) trap_d = 1'b1;
      end
      MEMADR: begin
        aluOut_d = addrSum;
        if (addrSum[1:0] != 2'b00) begin
          state_d = TRAP;
          trap_d  = 1'b1;
        end else begin
          memReq_d  = 1'b1;
          memAddr_d = addrSum[ADDR_W-1:0];
          if (opcode == OP_STORE) begin
            memWe_d    = 1'b1;
            memWdata_d = b_q;
            state_d    = MEMWRITE;
          end else begin
            memWe_d = 1'b0;
            state_d = MEMREAD;
          end
        end
      end
      MEMREAD: begin
        if (memReq_q && i_memAck) begin
          mdr_d    = i_memRdata;
          memReq_d = 1'b0;
          state_d  = MEMWB;
        end
      end
      MEMWB: begin
        rfWe      = 1'b1;
        rfWdata   = mdr_q;
        retire    = 1'b1;
        state_d   = FETCH;
        memReq_d  = 1'b1;
        memWe_d   = 1'b0;
        memAddr_d = pc_q;
      end
      MEMWRITE: begin
        if (memReq_q && i_memAck) begin
          retire    = 1'b1;
          state_d   = FETCH;
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = pc_q;
        end
      end
      EXECR, EXECI: begin
        aluOut_d = aluResult;
        state_d  = ALUWB;
      end
      ALUWB: begin
        rfWe      = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
        memReq_d  = 1'b1;
        memWe_d   = 1'b0;
        memAddr_d = pc_q;
      end
      BEQ: begin
        if (a_q == b_q) begin
          if (branchTarget[1]) begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end else begin
            pc_d      = branchTarget;
            retire    = 1'b1;
            state_d   = FETCH;
            memReq_d  = 1'b1;
            memWe_d   = 1'b0;
            memAddr_d = branchTarget;
          end
        end else begin
          retire    = 1'b1;
          state_d   = FETCH;
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = pc_q;
        end
      end
      JAL: begin
        if (branchTarget[1]) begin
          state_d = TRAP;
          trap_d  = 1'b1;
        end else begin
          pc_d     = branchTarget;
          aluOut_d = linkAddr;
          state_d  = ALUWB;
        end
      end
      TRAP: begin
        memReq_d = 1'b0;
        trap_d   = 1'b1;
      end
      default: begin
        state_d  = TRAP;
        trap_d   = 1'b1;
        memReq_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset drops any request at once
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q    <= FETCH;
      pc_q       <= RESET_ADDR;
      oldPc_q    <= RESET_ADDR;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluOut_q   <= '0;
      mdr_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= RESET_ADDR;
      memWdata_q <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      oldPc_q    <= oldPc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluOut_q   <= aluOut_d;
      mdr_q      <= mdr_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      trap_q     <= trap_d;
    end
  end

  // Register file is not reset; x0 is never written, and the read mux forces it to zero
  always_ff @(posedge i_clk) begin
    if (rfWe && (rd != 5'd0)) regs[rd] <= rfWdata;
  end

  assign o_memReq   = memReq_q;
  assign o_memWe    = memWe_q;
  assign o_memAddr  = memAddr_q;
  assign o_memWdata = memWdata_q;
  assign o_trap     = trap_q;
  assign o_retire   = retire;
  assign o_pc       = (state_q == FETCH) ? pc_q : oldPc_q;

endmodule
